operator_scheduler: RTL and testbench
=====================================

Name: operator_scheduler

Overview:
- Sequences the voice-operator phase/modulation/envelope pipeline once per audio sample frame.
- Issues every VoiceOperatorID in fixed order, one per clock.
- Tracks pipeline drain and pulses sample-ready for the mixer.
- Buffers host algorithm-configuration writes and releases them only outside the issue window, so algorithm words never change while voices are being read in the middle of a frame.

Parameters:
- NUM_VOICES, 32, voices per frame.
- NUM_OPERATORS, 8, operators per voice.
- PIPE_LATENCY, 8, cycles from ID issue to the modulator's final output register.
- FRAME_CYCLES, 512, clocks per sample frame. Elaboration error if FRAME_CYCLES < NUM_VOICES*NUM_OPERATORS + PIPE_LATENCY + 1.
- FIFO_DEPTH, 4, host write buffer entries (power of two).

Ports:
- i_Clock  in  1  system clock.
- i_Reset_n  in  1  synchronous, active-low reset.
- i_Enable  in  1  run frames while high.
- o_VoiceOperator  out  VoiceOperatorID_t  ID issued this cycle.
- o_Valid  out  1  o_VoiceOperator is a real slot.
- o_FrameStart  out  1  pulse with slot 0.
- o_SampleReady  out  1  pulse when the last slot exits the pipeline.
- o_Busy  out  1  state != STOPPED.
- i_HostWriteEnable  in  1  host write request.
- i_HostWriteAddr  in  VoiceOperatorID_t  target slot.
- i_HostWriteData  in  16  config word.
- o_HostWriteReady  out  1  FIFO can accept.
- o_Overflow  out  1  sticky: write attempted while not ready.
- o_AlgorithmWriteEnable  out  1  to modulator i_AlgorithmWriteEnable.
- o_ConfigWriteAddr  out  VoiceOperatorID_t  to modulator.
- o_ConfigWriteData  out  16  to modulator.

Behaviour:
- One clock (i_Clock). Reset is synchronous and active-low (i_Reset_n); the polarity and synchronicity are fixed.
- SLOTS = NUM_VOICES*NUM_OPERATORS.
- States and transitions:
  - STOPPED: idle.
  - ISSUE: SLOTS cycles.
  - DRAIN: PIPE_LATENCY cycles.
  - GAP: FRAME_CYCLES-SLOTS-PIPE_LATENCY cycles (>=1).
  - STOPPED -> ISSUE: the cycle after i_Enable is sampled high.
  - ISSUE -> DRAIN -> GAP: by counter.
  - End of GAP: go to ISSUE if i_Enable=1, else STOPPED. Frames are back-to-back with exactly FRAME_CYCLES period.
- i_Enable falling mid-frame does not abort: the frame completes through GAP.
- ISSUE ordering: voice outer 0..NUM_VOICES-1, operator inner 0..NUM_OPERATORS-1; o_VoiceOperator = makeVoiceOperatorID(voice, op).
- ISSUE outputs: o_Valid=1. o_FrameStart=1 only on slot 0.
- o_VoiceOperator outside ISSUE: holds 0, o_Valid=0.
- o_SampleReady: 1 on the final DRAIN cycle only, i.e. PIPE_LATENCY cycles after the last-slot cycle.
- Host FIFO push:
  - Write accepted when i_HostWriteEnable && o_HostWriteReady. o_HostWriteReady = !full && reset deasserted.
  - Write while not ready: dropped, o_Overflow set. o_Overflow clears only on reset.
- Host FIFO pop:
  - Pops only when state is DRAIN, GAP or STOPPED and the FIFO is non-empty.
  - At most one pop per cycle, registered: o_AlgorithmWriteEnable=1 with the popped addr/data the cycle after the pop decision.
  - No pop on the last GAP cycle when i_Enable=1, so no write lands in the modulator in the same cycle as slot 0.
  - Pushes are accepted in every state, including ISSUE.
- Simultaneous push/pop:
  - Non-full: both occur, count unchanged.
  - Full: push refused (ready already low), pop proceeds.
- FIFO order: strict FIFO; writes to the same address apply in arrival order.
- Reset (including mid-frame):
  - State STOPPED, all counters 0, FIFO flushed.
  - All outputs 0 during reset, including o_HostWriteReady and o_Overflow.

Optional Feature:
- Macro: OPERATOR_SCHEDULER_FRAME_COUNTER_EN.
- Defined:
  - Adds output o_FrameCount [15:0].
  - Resets to 0; increments by 1 in the cycle o_FrameStart is 1.
  - Wraps 0xFFFF -> 0.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Params NUM_VOICES=2, NUM_OPERATORS=8, PIPE_LATENCY=8, FRAME_CYCLES=32; release reset, i_Enable=1 -> o_FrameStart at cycle 1; o_Valid high 16 cycles with IDs voice0 op0..7 then voice1 op0..7; o_SampleReady 8 cycles after the last slot; next o_FrameStart exactly 32 cycles after the first.
- Push 3 host writes (addr 5/0x0123, addr 5/0x0456, addr 9/0x07FF) during ISSUE -> no o_AlgorithmWriteEnable until DRAIN; then 3 consecutive pulses in push order.
- With FRAME_CYCLES=26 (GAP=2) and the FIFO holding 4 entries at DRAIN start -> all 4 popped in DRAIN; none on the last GAP cycle; o_AlgorithmWriteEnable=0 during slot 0.
- Fill the FIFO (4) during ISSUE, then a 5th write -> o_HostWriteReady=0, 5th dropped, o_Overflow=1 and stays 1 through later frames until reset.
- Drop i_Enable at slot 3 -> frame completes, o_SampleReady still pulses, then STOPPED with o_Busy=0. Re-raise i_Enable -> slot 0 the next cycle.
- Assert i_Reset_n=0 at slot 10 with 2 FIFO entries -> next cycle all outputs 0, FIFO empty; no config writes after release. With the macro defined: o_FrameCount is 0 after reset and equals 3 after 3 frames.

Source files
------------

// File: rtl/operator_scheduler.sv
// Per-frame voice/operator issue sequencer with a host config write FIFO; IDs issue 1/clk, config writes land 1 clk after pop.
// Host backpressure via o_HostWriteReady (FIFO full); define OPERATOR_SCHEDULER_FRAME_COUNTER_EN to add o_FrameCount.
module operator_scheduler #(
  parameter int NUM_VOICES    = 32,
  parameter int NUM_OPERATORS = 8,
  parameter int PIPE_LATENCY  = 8,
  parameter int FRAME_CYCLES  = 512,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                                          i_Clock,
  input  logic                                          i_Reset_n,
  input  logic                                          i_Enable,
  output logic [$clog2(NUM_VOICES*NUM_OPERATORS)-1:0]  o_VoiceOperator,
  output logic                                          o_Valid,
  output logic                                          o_FrameStart,
  output logic                                          o_SampleReady,
  output logic                                          o_Busy,
  input  logic                                          i_HostWriteEnable,
  input  logic [$clog2(NUM_VOICES*NUM_OPERATORS)-1:0]  i_HostWriteAddr,
  input  logic [15:0]                                   i_HostWriteData,
  output logic                                          o_HostWriteReady,
  output logic                                          o_Overflow,
  output logic                                          o_AlgorithmWriteEnable,
  output logic [$clog2(NUM_VOICES*NUM_OPERATORS)-1:0]  o_ConfigWriteAddr,
  output logic [15:0]                                   o_ConfigWriteData
`ifdef OPERATOR_SCHEDULER_FRAME_COUNTER_EN
  ,
  output logic [15:0]                                   o_FrameCount
`endif
);

  localparam int SLOTS      = NUM_VOICES * NUM_OPERATORS;
  localparam int ID_W       = $clog2(SLOTS);
  localparam int GAP_CYCLES = FRAME_CYCLES - SLOTS - PIPE_LATENCY;
  localparam int CNT_W      = $clog2(FRAME_CYCLES);
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int FCNT_W     = PTR_W + 1;

  localparam logic [CNT_W-1:0]  ISSUE_LAST = CNT_W'(SLOTS - 1);
  localparam logic [CNT_W-1:0]  DRAIN_LAST = CNT_W'(PIPE_LATENCY - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [FCNT_W-1:0] FIFO_FULL  = FCNT_W'(FIFO_DEPTH);

  generate
    if (FRAME_CYCLES < SLOTS + PIPE_LATENCY + 1) begin : g_bad_frame
      $error("FRAME_CYCLES too small for NUM_VOICES*NUM_OPERATORS + PIPE_LATENCY + 1");
    end
    if ((1 << PTR_W) != FIFO_DEPTH) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of two");
    end
  endgenerate

  typedef enum logic [1:0] {
    STOPPED = 2'd0,
    ISSUE   = 2'd1,
    DRAIN   = 2'd2,
    GAP     = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             issue_vld;
  logic             frame_start;
  logic             sample_rdy;
  logic             pop_ok;

  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      state <= STOPPED;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // pop_ok keeps config writes out of the issue window, including the cycle that
  // would land a write on top of slot 0.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt + CNT_W'(1);
    issue_vld   = 1'b0;
    frame_start = 1'b0;
    sample_rdy  = 1'b0;
    pop_ok      = 1'b0;
    case (state)
      STOPPED: begin
        cnt_nxt = '0;
        pop_ok  = !i_Enable;
        if (i_Enable) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        issue_vld   = 1'b1;
        frame_start = (cnt == '0);
        if (cnt == ISSUE_LAST) begin
          state_nxt = DRAIN;
          cnt_nxt   = '0;
        end
      end
      DRAIN: begin
        pop_ok = 1'b1;
        if (cnt == DRAIN_LAST) begin
          sample_rdy = 1'b1;
          state_nxt  = GAP;
          cnt_nxt    = '0;
        end
      end
      GAP: begin
        pop_ok = 1'b1;
        if (cnt == GAP_LAST) begin
          pop_ok    = !i_Enable;
          cnt_nxt   = '0;
          state_nxt = i_Enable ? ISSUE : STOPPED;
        end
      end
      default: begin
        state_nxt = STOPPED;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign o_Valid         = issue_vld & i_Reset_n;
  assign o_VoiceOperator = o_Valid ? cnt[ID_W-1:0] : '0;
  assign o_FrameStart    = frame_start & i_Reset_n;
  assign o_SampleReady   = sample_rdy & i_Reset_n;
  assign o_Busy          = (state != STOPPED) & i_Reset_n;

  logic [ID_W-1:0]   fifo_addr [FIFO_DEPTH];
  logic [15:0]       fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [FCNT_W-1:0] fifo_cnt;
  logic              fifo_full, fifo_empty;
  logic              push, pop;
  logic              overflow_q;
  logic              awe_q;
  logic [ID_W-1:0]   cfg_addr_q;
  logic [15:0]       cfg_data_q;

  assign fifo_full        = (fifo_cnt == FIFO_FULL);
  assign fifo_empty       = (fifo_cnt == '0);
  assign o_HostWriteReady = !fifo_full && i_Reset_n;
  assign push             = i_HostWriteEnable && o_HostWriteReady;
  assign pop              = !fifo_empty && pop_ok;

  always_ff @(posedge i_Clock) begin
    if (push) begin
      fifo_addr[wr_ptr] <= i_HostWriteAddr;
      fifo_data[wr_ptr] <= i_HostWriteData;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
      overflow_q <= 1'b0;
      awe_q      <= 1'b0;
      cfg_addr_q <= '0;
      cfg_data_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr     <= rd_ptr + PTR_W'(1);
        cfg_addr_q <= fifo_addr[rd_ptr];
        cfg_data_q <= fifo_data[rd_ptr];
      end
      fifo_cnt   <= fifo_cnt + FCNT_W'(push) - FCNT_W'(pop);
      overflow_q <= overflow_q | (i_HostWriteEnable & !o_HostWriteReady);
      awe_q      <= pop;
    end
  end

  assign o_Overflow             = overflow_q & i_Reset_n;
  assign o_AlgorithmWriteEnable = awe_q & i_Reset_n;
  assign o_ConfigWriteAddr      = i_Reset_n ? cfg_addr_q : '0;
  assign o_ConfigWriteData      = i_Reset_n ? cfg_data_q : '0;

`ifdef OPERATOR_SCHEDULER_FRAME_COUNTER_EN
  logic [15:0] frame_cnt;

  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      frame_cnt <= '0;
    end else if (frame_start) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end

  assign o_FrameCount = i_Reset_n ? frame_cnt : '0;
`endif

endmodule

// File: tb/tb_operator_scheduler.sv
// Directed bench for operator_scheduler: two instances (32- and 26-cycle frames) share clock, reset and enable.
module tb_operator_scheduler;

  logic        clk = 1'b0;
  logic        rst_n, en;
  logic        we1, we2;
  logic [3:0]  wa1, wa2;
  logic [15:0] wd1, wd2;

  logic [3:0]  id1, id2, ca1, ca2;
  logic [15:0] cd1, cd2;
  logic        vld1, vld2, fs1, fs2, sr1, sr2, busy1, busy2;
  logic        rdy1, rdy2, ovf1, ovf2, awe1, awe2;
`ifdef OPERATOR_SCHEDULER_FRAME_COUNTER_EN
  logic [15:0] fc1, fc2;
`endif

  typedef logic [19:0] wr_t;
  wr_t sb1[$];
  wr_t sb2[$];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  operator_scheduler #(
    .NUM_VOICES(2), .NUM_OPERATORS(8), .PIPE_LATENCY(8), .FRAME_CYCLES(32), .FIFO_DEPTH(4)
  ) dut1 (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_Enable(en),
    .o_VoiceOperator(id1), .o_Valid(vld1), .o_FrameStart(fs1), .o_SampleReady(sr1), .o_Busy(busy1),
    .i_HostWriteEnable(we1), .i_HostWriteAddr(wa1), .i_HostWriteData(wd1),
    .o_HostWriteReady(rdy1), .o_Overflow(ovf1),
    .o_AlgorithmWriteEnable(awe1), .o_ConfigWriteAddr(ca1), .o_ConfigWriteData(cd1)
`ifdef OPERATOR_SCHEDULER_FRAME_COUNTER_EN
    , .o_FrameCount(fc1)
`endif
  );

  operator_scheduler #(
    .NUM_VOICES(2), .NUM_OPERATORS(8), .PIPE_LATENCY(8), .FRAME_CYCLES(26), .FIFO_DEPTH(4)
  ) dut2 (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_Enable(en),
    .o_VoiceOperator(id2), .o_Valid(vld2), .o_FrameStart(fs2), .o_SampleReady(sr2), .o_Busy(busy2),
    .i_HostWriteEnable(we2), .i_HostWriteAddr(wa2), .i_HostWriteData(wd2),
    .o_HostWriteReady(rdy2), .o_Overflow(ovf2),
    .o_AlgorithmWriteEnable(awe2), .o_ConfigWriteAddr(ca2), .o_ConfigWriteData(cd2)
`ifdef OPERATOR_SCHEDULER_FRAME_COUNTER_EN
    , .o_FrameCount(fc2)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive1(input logic [3:0] a, input logic [15:0] d, input bit accepted);
    we1 = 1'b1; wa1 = a; wd1 = d;
    if (accepted) sb1.push_back({a, d});
  endtask

  task automatic drive2(input logic [3:0] a, input logic [15:0] d);
    we2 = 1'b1; wa2 = a; wd2 = d;
    sb2.push_back({a, d});
  endtask

  task automatic score(input int k);
    wr_t e;
    if (awe1) begin
      if (sb1.size() == 0) chk($sformatf("wr1_unexpected@%0d", k), awe1, 0);
      else begin e = sb1.pop_front(); chk($sformatf("wr1_data@%0d", k), {ca1, cd1}, e); end
    end
    if (awe2) begin
      if (sb2.size() == 0) chk($sformatf("wr2_unexpected@%0d", k), awe2, 0);
      else begin e = sb2.pop_front(); chk($sformatf("wr2_data@%0d", k), {ca2, cd2}, e); end
    end
  endtask

  // Expected behaviour from the frame schedule: dut1 frames start at 0,32,64; dut2 at 0,26,52;
  // enable drops during k=67 so dut1 stops after k=95 and dut2 after k=77.
  task automatic check_cycle(input int k);
    int p1, p2, eid1, eid2;
    bit ev1, ev2, eawe1, eawe2;
    p1 = (k < 96) ? (k % 32) : -1;
    p2 = (k < 78) ? (k % 26) : -1;
    ev1 = (p1 >= 0) && (p1 < 16);
    ev2 = (p2 >= 0) && (p2 < 16);
    eid1 = ev1 ? ((p1 / 8) * 8 + (p1 % 8)) : 0;
    eid2 = ev2 ? ((p2 / 8) * 8 + (p2 % 8)) : 0;
    eawe1 = (k >= 17 && k <= 19) || (k >= 49 && k <= 52);
    eawe2 = (k >= 17 && k <= 20) || (k == 43);
    chk($sformatf("valid1@%0d", k), vld1, ev1);
    chk($sformatf("id1@%0d", k), id1, eid1);
    chk($sformatf("fstart1@%0d", k), fs1, p1 == 0);
    chk($sformatf("sready1@%0d", k), sr1, p1 == 23);
    chk($sformatf("busy1@%0d", k), busy1, p1 >= 0);
    chk($sformatf("awe1@%0d", k), awe1, eawe1);
    chk($sformatf("ovf1@%0d", k), ovf1, k >= 39);
    chk($sformatf("valid2@%0d", k), vld2, ev2);
    chk($sformatf("id2@%0d", k), id2, eid2);
    chk($sformatf("fstart2@%0d", k), fs2, p2 == 0);
    chk($sformatf("sready2@%0d", k), sr2, p2 == 23);
    chk($sformatf("busy2@%0d", k), busy2, p2 >= 0);
    chk($sformatf("awe2@%0d", k), awe2, eawe2);
    chk($sformatf("ovf2@%0d", k), ovf2, 0);
    if (k == 10) chk("ready2_full", rdy2, 0);
    if (k == 37) chk("ready1_three", rdy1, 1);
    if (k == 38) chk("ready1_full", rdy1, 0);
`ifdef OPERATOR_SCHEDULER_FRAME_COUNTER_EN
    if (k == 96) chk("fcount1_3", fc1, 3);
    if (k == 78) chk("fcount2_3", fc2, 3);
`endif
    score(k);
  endtask

  task automatic drive_cycle(input int k);
    we1 = 1'b0; we2 = 1'b0;
    case (k)
      2: begin drive1(4'd5, 16'h0123, 1); drive2(4'd0, 16'hA000); end
      3: begin drive1(4'd5, 16'h0456, 1); drive2(4'd7, 16'hA007); end
      4: begin drive1(4'd9, 16'h07FF, 1); drive2(4'd8, 16'hA008); end
      5: drive2(4'd15, 16'hA00F);
      24: drive2(4'd6, 16'hBEEF);
      34: drive1(4'd1, 16'h1111, 1);
      35: drive1(4'd2, 16'h2222, 1);
      36: drive1(4'd3, 16'h3333, 1);
      37: drive1(4'd4, 16'h4444, 1);
      38: drive1(4'd15, 16'hDEAD, 0);
      67: en = 1'b0;
      100: en = 1'b1;
      default: ;
    endcase
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid1"}, vld1, 0);  chk({tag, "_id1"}, id1, 0);
    chk({tag, "_fs1"}, fs1, 0);      chk({tag, "_sr1"}, sr1, 0);
    chk({tag, "_busy1"}, busy1, 0);  chk({tag, "_ready1"}, rdy1, 0);
    chk({tag, "_ovf1"}, ovf1, 0);    chk({tag, "_awe1"}, awe1, 0);
    chk({tag, "_ca1"}, ca1, 0);      chk({tag, "_cd1"}, cd1, 0);
    chk({tag, "_valid2"}, vld2, 0);  chk({tag, "_busy2"}, busy2, 0);
    chk({tag, "_ready2"}, rdy2, 0);  chk({tag, "_awe2"}, awe2, 0);
    chk({tag, "_cd2"}, cd2, 0);
`ifdef OPERATOR_SCHEDULER_FRAME_COUNTER_EN
    chk({tag, "_fc1"}, fc1, 0);
`endif
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0;
    we1 = 1'b0; wa1 = '0; wd1 = '0;
    we2 = 1'b0; wa2 = '0; wd2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");

    rst_n = 1'b1; en = 1'b1;
    for (int k = 0; k <= 100; k++) begin
      @(posedge clk); #1;
      check_cycle(k);
      drive_cycle(k);
    end
    chk("sb1_drained", sb1.size(), 0);
    chk("sb2_drained", sb2.size(), 0);

    for (int j = 101; j <= 111; j++) begin
      @(posedge clk); #1;
      chk($sformatf("restart_valid1@%0d", j), vld1, 1);
      chk($sformatf("restart_id1@%0d", j), id1, j - 101);
      chk($sformatf("restart_fs1@%0d", j), fs1, j == 101);
      chk($sformatf("restart_fs2@%0d", j), fs2, j == 101);
      chk($sformatf("restart_awe1@%0d", j), awe1, 0);
      score(j);
      we1 = 1'b0;
      if (j == 102) drive1(4'd3, 16'h0C03, 1);
      if (j == 103) drive1(4'd12, 16'h0C0C, 1);
      if (j == 111) begin rst_n = 1'b0; en = 1'b0; end
    end

    @(posedge clk); #1;
    check_all_zero("midreset");
    sb1.delete();
    sb2.delete();
    rst_n = 1'b1;

    for (int j = 0; j < 40; j++) begin
      @(posedge clk); #1;
      chk($sformatf("post_awe1@%0d", j), awe1, 0);
      chk($sformatf("post_awe2@%0d", j), awe2, 0);
      chk($sformatf("post_busy1@%0d", j), busy1, 0);
      chk($sformatf("post_valid1@%0d", j), vld1, 0);
      if (j == 0) begin
        chk("post_ready1", rdy1, 1);
        chk("post_ovf1", ovf1, 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
